// File: rtl/sketch_pkg.sv
// Shared types and constants for the count-min sketch counter update path.
// Request layout, FSM encoding and counter geometry live here.
package sketch_pkg;

    localparam int COL_BITS  = 16;
    localparam int ROW_BITS  = 3;
    localparam int CNT_WIDTH = 32;
    localparam int BYTE_BITS = 16;
    localparam int ADDR_W    = ROW_BITS + COL_BITS;
    localparam int REQ_W     = ADDR_W + BYTE_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        WR      = 2'd3
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]    addr;
        logic [BYTE_BITS-1:0] byte_cnt;
    } req_t;

endpackage

// File: rtl/sketch_req_fifo.sv
// First-word-fall-through request buffer in front of the RMW engine.
// DEPTH must be a power of two so the pointers wrap naturally.
module sketch_req_fifo
    import sketch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = REQ_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rptr_q];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage; contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/sketch_counter_update.sv
// Saturating read-modify-write of count-min sketch counters in SRAM.
// One update in flight at a time; requests queue in a small FIFO.
module sketch_counter_update
    import sketch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int RD_TIMEOUT = 64
) (
    input  logic                 memclk,
    input  logic                 reset,
    input  logic [31:0]          universal_data,
    input  logic [15:0]          sram_id,
    input  logic [15:0]          packet_byte,
    input  logic                 upd_valid,
    output logic                 upd_ready,
    output logic [ADDR_W-1:0]    sram_addr,
    output logic                 sram_rd_en,
    input  logic [CNT_WIDTH-1:0] sram_rd_data,
    input  logic                 sram_rd_valid,
    output logic                 sram_wr_en,
    output logic [CNT_WIDTH-1:0] sram_wr_data,
    input  logic                 sram_ready,
    output logic                 busy,
    output logic [31:0]          upd_count,
    output logic                 sat_flag,
    output logic                 timeout_flag
);

    localparam int TW = $clog2(RD_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(RD_TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BYTE_BITS-1:0] byte_q, byte_d;
    logic [CNT_WIDTH-1:0] sum_q, sum_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 rd_en_q, rd_en_d;
    logic                 wr_en_q, wr_en_d;
    logic [31:0]          cnt_q, cnt_d;
    logic                 sat_q, sat_d;
    logic                 to_q, to_d;

    req_t                 push_req;
    req_t                 pop_req;
    logic [REQ_W-1:0]     fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [CNT_WIDTH:0]   sum_w;
    logic                 unused_bits;

    assign push_req.addr     = {sram_id[ROW_BITS-1:0],
                                universal_data[COL_BITS-1:0]};
    assign push_req.byte_cnt = packet_byte;
    assign pop_req           = req_t'(fifo_dout);
    assign fifo_push         = upd_valid && upd_ready;
    assign unused_bits       = ^{universal_data[31:COL_BITS],
                                 sram_id[15:ROW_BITS]};

    sketch_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (REQ_W)
    ) u_fifo (
        .clk   (memclk),
        .rst   (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (push_req),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // One extra bit catches the carry that signals saturation.
    assign sum_w = {1'b0, sram_rd_data}
                 + {{(CNT_WIDTH + 1 - BYTE_BITS){1'b0}}, byte_q};

    // Next-state and strobe logic for the RMW sequence.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        byte_d   = byte_q;
        sum_d    = sum_q;
        timer_d  = timer_q;
        rd_en_d  = rd_en_q;
        wr_en_d  = wr_en_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        to_d     = to_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    addr_d   = pop_req.addr;
                    byte_d   = pop_req.byte_cnt;
                    rd_en_d  = 1'b1;
                    state_d  = RD_REQ;
                end
            end
            RD_REQ: begin
                if (sram_ready) begin
                    rd_en_d = 1'b0;
                    timer_d = '0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (sram_rd_valid) begin
                    if (sum_w[CNT_WIDTH]) begin
                        sum_d = '1;
                        sat_d = 1'b1;
                    end else begin
                        sum_d = sum_w[CNT_WIDTH-1:0];
                    end
                    wr_en_d = 1'b1;
                    state_d = WR;
                end else if (timer_q == TO_LAST) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WR: begin
                if (sram_ready) begin
                    wr_en_d = 1'b0;
                    cnt_d   = cnt_q + 32'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any update in flight.
    always_ff @(posedge memclk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            byte_q  <= '0;
            sum_q   <= '0;
            timer_q <= '0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            byte_q  <= byte_d;
            sum_q   <= sum_d;
            timer_q <= timer_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            to_q    <= to_d;
        end
    end

    assign upd_ready    = !fifo_full;
    assign busy         = (state_q != IDLE) || !fifo_empty;
    assign sram_addr    = addr_q;
    assign sram_rd_en   = rd_en_q;
    assign sram_wr_en   = wr_en_q;
    assign sram_wr_data = sum_q;
    assign upd_count    = cnt_q;
    assign sat_flag     = sat_q;
    assign timeout_flag = to_q;

endmodule

// File: tb/tb_sketch_counter_update.sv
// Bench for sketch_counter_update: SRAM model with fixed read latency,
// write scoreboard, table-driven updates and multi-cycle corner cases.
module tb_sketch_counter_update;

    localparam int LAT = 2;

    logic        memclk;
    logic        reset;
    logic [31:0] universal_data;
    logic [15:0] sram_id;
    logic [15:0] packet_byte;
    logic        upd_valid;
    logic        upd_ready;
    logic [18:0] sram_addr;
    logic        sram_rd_en;
    logic [31:0] sram_rd_data;
    logic        sram_rd_valid;
    logic        sram_wr_en;
    logic [31:0] sram_wr_data;
    logic        sram_ready;
    logic        busy;
    logic [31:0] upd_count;
    logic        sat_flag;
    logic        timeout_flag;

    sketch_counter_update #(
        .FIFO_DEPTH (4),
        .RD_TIMEOUT (64)
    ) dut (
        .memclk         (memclk),
        .reset          (reset),
        .universal_data (universal_data),
        .sram_id        (sram_id),
        .packet_byte    (packet_byte),
        .upd_valid      (upd_valid),
        .upd_ready      (upd_ready),
        .sram_addr      (sram_addr),
        .sram_rd_en     (sram_rd_en),
        .sram_rd_data   (sram_rd_data),
        .sram_rd_valid  (sram_rd_valid),
        .sram_wr_en     (sram_wr_en),
        .sram_wr_data   (sram_wr_data),
        .sram_ready     (sram_ready),
        .busy           (busy),
        .upd_count      (upd_count),
        .sat_flag       (sat_flag),
        .timeout_flag   (timeout_flag)
    );

    typedef struct {
        logic [18:0] addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] ud;
        logic [15:0] id;
        logic [15:0] nb;
        logic [31:0] init;
        logic [18:0] addr;
        logic [31:0] data;
        logic        sat;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rd_total = 0;
    int          wr_total = 0;
    int          last_rd_cyc = 0;
    int          last_wr_cyc = 0;
    int          prev_wr_cyc = 0;
    int          both_hi = 0;
    int          rd_cnt = 0;
    logic [31:0] rd_hold = '0;
    bit          mute_next = 0;
    bit          stray_rd = 0;
    bit [31:0]   mem [bit [18:0]];
    exp_t        exp_q [$];
    exp_t        e;
    vec_t        vt [6];

    initial begin
        memclk = 1'b0;
        forever #5 memclk = ~memclk;
    end

    initial forever begin
        @(posedge memclk);
        cyc++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: run did not finish, got cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    // SRAM model and write scoreboard, evaluated mid-cycle.
    initial forever begin
        @(negedge memclk);
        sram_rd_valid = 1'b0;
        if (stray_rd) begin
            sram_rd_valid = 1'b1;
            sram_rd_data  = 32'hDEAD_BEEF;
            stray_rd      = 0;
        end
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                sram_rd_valid = 1'b1;
                sram_rd_data  = rd_hold;
            end
        end
        if (sram_rd_en && sram_wr_en) both_hi++;
        if (sram_rd_en && sram_ready) begin
            rd_total++;
            last_rd_cyc = cyc;
            if (mute_next) begin
                mute_next = 0;
            end else begin
                rd_cnt  = LAT;
                rd_hold = mem[sram_addr];
            end
        end
        if (sram_wr_en && sram_ready) begin
            wr_total++;
            prev_wr_cyc = last_wr_cyc;
            last_wr_cyc = cyc;
            mem[sram_addr] = sram_wr_data;
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", {13'd0, sram_addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", {13'd0, sram_addr}, {13'd0, e.addr});
                chk("write_data", sram_wr_data, e.data);
            end
        end
    end

    task automatic push_req(input logic [31:0] ud, input logic [15:0] id,
                            input logic [15:0] nb, output bit stalled);
        int n;
        universal_data = ud;
        sram_id        = id;
        packet_byte    = nb;
        upd_valid      = 1'b1;
        @(negedge memclk);
        stalled = !upd_ready;
        n = 0;
        while (!upd_ready && n < 500) begin
            @(negedge memclk);
            n++;
        end
        if (!upd_ready) begin
            checks++;
            errors++;
            $display("FAIL push_accept: got upd_ready 0 expected 1");
        end
        @(posedge memclk);
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic wait_writes(input int target);
        int n;
        n = 0;
        while (wr_total < target && n < 500) begin
            @(negedge memclk);
            n++;
        end
        chk("write_arrived", wr_total, target);
    endtask

    task automatic wait_strobe(input bit want_wr);
        int n;
        n = 0;
        while (!(want_wr ? sram_wr_en : sram_rd_en) && n < 200) begin
            @(negedge memclk);
            n++;
        end
        chk(want_wr ? "wr_strobe_seen" : "rd_strobe_seen",
            {31'd0, want_wr ? sram_wr_en : sram_rd_en}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_upd_ready"}, {31'd0, upd_ready}, 32'd1);
        chk({tag, "_rd_en"}, {31'd0, sram_rd_en}, 32'd0);
        chk({tag, "_wr_en"}, {31'd0, sram_wr_en}, 32'd0);
        chk({tag, "_addr"}, {13'd0, sram_addr}, 32'd0);
        chk({tag, "_wr_data"}, sram_wr_data, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_upd_count"}, upd_count, 32'd0);
        chk({tag, "_sat"}, {31'd0, sat_flag}, 32'd0);
        chk({tag, "_timeout"}, {31'd0, timeout_flag}, 32'd0);
    endtask

    initial begin
        bit   st;
        int   stall_at;
        int   w0;
        int   r0;
        int   n;
        bit   stable;
        logic [18:0] a0;

        reset          = 1'b1;
        universal_data = '0;
        sram_id        = '0;
        packet_byte    = '0;
        upd_valid      = 1'b0;
        sram_ready     = 1'b1;
        sram_rd_valid  = 1'b0;
        sram_rd_data   = '0;

        vt[0] = '{32'h0000_1234, 16'h0002, 16'd64, 32'd100,
                  19'h21234, 32'd164, 1'b0};
        vt[1] = '{32'hABCD_5678, 16'hFFF7, 16'hFFFF, 32'h0001_0000,
                  19'h75678, 32'h0001_FFFF, 1'b0};
        vt[2] = '{32'h0000_FFFF, 16'h0000, 16'h0000, 32'hFFFF_FFFF,
                  19'h0FFFF, 32'hFFFF_FFFF, 1'b0};
        vt[3] = '{32'h0000_0000, 16'h0001, 16'h00FF, 32'hFFFF_FF00,
                  19'h10000, 32'hFFFF_FFFF, 1'b0};
        vt[4] = '{32'h0000_0042, 16'h0005, 16'h0020, 32'hFFFF_FFF0,
                  19'h50042, 32'hFFFF_FFFF, 1'b1};
        vt[5] = '{32'h1234_0001, 16'h0003, 16'h0001, 32'h0000_0000,
                  19'h30001, 32'h0000_0001, 1'b1};

        repeat (3) @(posedge memclk);
        #1;
        reset = 1'b0;
        @(negedge memclk);
        check_reset_outputs("reset");
        @(posedge memclk);
        #1;

        // Table of single updates, ready tied high.
        for (int i = 0; i < 6; i++) begin
            w0 = wr_total;
            mem[vt[i].addr] = vt[i].init;
            exp_q.push_back('{addr: vt[i].addr, data: vt[i].data});
            push_req(vt[i].ud, vt[i].id, vt[i].nb, st);
            wait_writes(w0 + 1);
            chk("rd_to_wr_cycles", last_wr_cyc - last_rd_cyc, 32'd3);
            @(negedge memclk);
            chk("vec_upd_count", upd_count, i + 1);
            chk("vec_sat_flag", {31'd0, sat_flag}, {31'd0, vt[i].sat});
            @(posedge memclk);
            #1;
        end

        // Burst of six to one address: four buffer, one in flight.
        w0 = wr_total;
        stall_at = -1;
        mem[19'h40777] = 32'd0;
        for (int k = 1; k <= 6; k++)
            exp_q.push_back('{addr: 19'h40777, data: k});
        for (int k = 0; k < 6; k++) begin
            push_req(32'h0000_0777, 16'h0004, 16'd1, st);
            if (st && stall_at < 0) stall_at = k;
        end
        chk("burst_first_stall", stall_at, 32'd5);
        wait_writes(w0 + 6);
        chk("burst_write_gap", last_wr_cyc - prev_wr_cyc, 32'd5);
        @(negedge memclk);
        chk("burst_final_value", mem[19'h40777], 32'd6);
        chk("burst_upd_count", upd_count, 32'd12);
        @(posedge memclk);
        #1;

        // Controller backpressure on both the read and write strobe.
        sram_ready = 1'b0;
        w0 = wr_total;
        r0 = rd_total;
        mem[19'h6BEEF] = 32'd7;
        exp_q.push_back('{addr: 19'h6BEEF, data: 32'd10});
        push_req(32'h0000_BEEF, 16'h0006, 16'd3, st);
        wait_strobe(1'b0);
        a0 = sram_addr;
        stable = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge memclk);
            if (!(sram_rd_en && !sram_wr_en && sram_addr == a0)) stable = 0;
        end
        chk("rd_hold_stable", {31'd0, stable}, 32'd1);
        chk("rd_hold_addr", {13'd0, a0}, 32'h6BEEF);
        @(posedge memclk);
        #1;
        sram_ready = 1'b1;
        @(posedge memclk);
        #1;
        sram_ready = 1'b0;
        wait_strobe(1'b1);
        stable = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge memclk);
            if (!(sram_wr_en && !sram_rd_en && sram_addr == 19'h6BEEF
                  && sram_wr_data == 32'd10)) stable = 0;
        end
        chk("wr_hold_stable", {31'd0, stable}, 32'd1);
        @(posedge memclk);
        #1;
        sram_ready = 1'b1;
        wait_writes(w0 + 1);
        @(negedge memclk);
        chk("bp_read_count", rd_total - r0, 32'd1);
        chk("bp_write_count", wr_total - w0, 32'd1);
        chk("bp_upd_count", upd_count, 32'd13);
        @(posedge memclk);
        #1;

        // Read timeout drops the first update; the queued one completes.
        mute_next = 1;
        w0 = wr_total;
        mem[19'h22222] = 32'd5;
        exp_q.push_back('{addr: 19'h22222, data: 32'd10});
        push_req(32'h0000_1111, 16'h0001, 16'd9, st);
        push_req(32'h0000_2222, 16'h0002, 16'd5, st);
        n = 0;
        while (!timeout_flag && n < 300) begin
            @(negedge memclk);
            n++;
        end
        chk("timeout_flag_set", {31'd0, timeout_flag}, 32'd1);
        chk("timeout_latency", cyc - last_rd_cyc, 32'd65);
        chk("timeout_no_write", wr_total - w0, 32'd0);
        wait_writes(w0 + 1);
        @(negedge memclk);
        chk("timeout_upd_count", upd_count, 32'd14);
        chk("timeout_sticky", {31'd0, timeout_flag}, 32'd1);
        @(posedge memclk);
        #1;

        // Reset while waiting for read data with two requests queued.
        mute_next = 1;
        push_req(32'h0000_3333, 16'h0003, 16'd1, st);
        push_req(32'h0000_4444, 16'h0004, 16'd1, st);
        push_req(32'h0000_5555, 16'h0005, 16'd1, st);
        repeat (5) @(posedge memclk);
        @(negedge memclk);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        @(posedge memclk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge memclk);
        #1;
        reset = 1'b0;
        mute_next = 0;
        w0 = wr_total;
        r0 = rd_total;
        @(negedge memclk);
        check_reset_outputs("midrst");
        @(posedge memclk);
        #1;
        stray_rd = 1;
        repeat (15) @(negedge memclk);
        chk("midrst_no_write", wr_total - w0, 32'd0);
        chk("midrst_no_read", rd_total - r0, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_upd_count", upd_count, 32'd0);
        @(posedge memclk);
        #1;

        // Normal operation resumes after reset.
        w0 = wr_total;
        mem[19'h00005] = 32'd9;
        exp_q.push_back('{addr: 19'h00005, data: 32'd10});
        push_req(32'h0000_0005, 16'h0000, 16'd1, st);
        wait_writes(w0 + 1);
        @(negedge memclk);
        chk("post_upd_count", upd_count, 32'd1);
        chk("post_sat_flag", {31'd0, sat_flag}, 32'd0);
        chk("post_timeout_flag", {31'd0, timeout_flag}, 32'd0);
        chk("strobes_overlap", both_hi, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
